// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and opcode constants for the RV64 fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_U  = 3'd1,
        IMM_S  = 3'd2,
        IMM_R  = 3'd3,
        IMM_SB = 3'd4,
        IMM_UJ = 3'd5
    } imm_type_e;

    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_imm32  = 7'b0011011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_reg32  = 7'b0111011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/imm_type_decode.sv
`default_nettype none
// ============================================================================
// imm_type_decode : opcode to immediate-format code and illegal flag
// Revision        : 1.0
// ============================================================================
module imm_type_decode
    import fetch_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_type,
    output logic       illegal
);

    always_comb begin
        imm_type = IMM_R;
        illegal  = 1'b0;
        case (opcode)
            c_op_imm, c_op_load, c_op_jalr, c_op_imm32: imm_type = IMM_I;
            c_op_lui, c_op_auipc:                       imm_type = IMM_U;
            c_op_store:                                 imm_type = IMM_S;
            c_op_reg, c_op_reg32:                       imm_type = IMM_R;
            c_op_branch:                                imm_type = IMM_SB;
            c_op_jal:                                   imm_type = IMM_UJ;
            default:                                    illegal  = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : RV64 instruction fetch, one outstanding request, skid buffer
// Revision    : 1.0
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        ifid_valid,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [2:0]  ifid_imm_type,
    output logic        ifid_illegal
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_req_pc;
    logic        r_skid_valid;
    logic [63:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        r_ifid_valid;
    logic [63:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic [2:0]  r_ifid_imm_type;
    logic        r_ifid_illegal;

    logic        w_stall_to_skid;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_resp_live;
    logic        w_from_skid;
    logic [31:0] w_load_instr;
    logic [63:0] w_load_pc;
    logic [63:0] w_redirect_target;
    logic [2:0]  w_dec_imm_type;
    logic        w_dec_illegal;

    // A response may be chased by the next request in the same cycle unless it must park in skid.
    assign w_stall_to_skid   = stall && r_ifid_valid;
    assign w_req_valid       = !reset && !redirect_valid && !r_skid_valid &&
                               ((r_state == S_REQ) ||
                                ((r_state == S_WAIT) && imem_resp_valid && !w_stall_to_skid));
    assign w_req_fire        = w_req_valid && imem_req_ready;
    assign w_resp_live       = imem_resp_valid && (r_state == S_WAIT);
    assign w_redirect_target = redirect_pc & ~64'h3;

    // IF/ID loads either the skid entry (on stall release) or the live response.
    assign w_from_skid  = r_skid_valid && !stall;
    assign w_load_instr = w_from_skid ? r_skid_instr : imem_resp_data;
    assign w_load_pc    = w_from_skid ? r_skid_pc    : r_req_pc;

    imm_type_decode u_imm_type_decode (
        .opcode   (w_load_instr[6:0]),
        .imm_type (w_dec_imm_type),
        .illegal  (w_dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_REQ;
            r_pc            <= RESET_PC;
            r_req_pc        <= '0;
            r_skid_valid    <= 1'b0;
            r_skid_pc       <= '0;
            r_skid_instr    <= c_nop_instr;
            r_ifid_valid    <= 1'b0;
            r_ifid_pc       <= '0;
            r_ifid_instr    <= c_nop_instr;
            r_ifid_imm_type <= IMM_I;
            r_ifid_illegal  <= 1'b0;
        end else if (redirect_valid) begin
            r_pc         <= w_redirect_target;
            r_ifid_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            if (r_state == S_WAIT) begin
                r_state <= imem_resp_valid ? S_REQ : S_DROP;
            end
        end else begin
            if (w_req_fire) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 64'd4;
            end

            case (r_state)
                S_REQ:   if (w_req_fire) r_state <= S_WAIT;
                S_WAIT:  if (imem_resp_valid) r_state <= w_req_fire ? S_WAIT : S_REQ;
                S_DROP:  if (imem_resp_valid) r_state <= S_REQ;
                default: r_state <= S_REQ;
            endcase

            if (!stall) begin
                if (r_skid_valid || w_resp_live) begin
                    r_ifid_valid    <= 1'b1;
                    r_ifid_pc       <= w_load_pc;
                    r_ifid_instr    <= w_load_instr;
                    r_ifid_imm_type <= w_dec_imm_type;
                    r_ifid_illegal  <= w_dec_illegal;
                    r_skid_valid    <= 1'b0;
                end else begin
                    r_ifid_valid <= 1'b0;
                end
            end else if (w_resp_live) begin
                if (r_ifid_valid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_pc    <= r_req_pc;
                    r_skid_instr <= imem_resp_data;
                end else begin
                    r_ifid_valid    <= 1'b1;
                    r_ifid_pc       <= w_load_pc;
                    r_ifid_instr    <= w_load_instr;
                    r_ifid_imm_type <= w_dec_imm_type;
                    r_ifid_illegal  <= w_dec_illegal;
                end
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign ifid_valid     = r_ifid_valid;
    assign ifid_pc        = r_ifid_pc;
    assign ifid_instr     = r_ifid_instr;
    assign ifid_imm_type  = r_ifid_imm_type;
    assign ifid_illegal   = r_ifid_illegal;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 64-bit RISC-V pipeline. It owns the PC and issues one instruction-memory request at a time over a valid/ready handshake. It absorbs stalls through a one-entry skid buffer and discards stale responses after a redirect. Its output is the IF/ID pipeline register: PC, instruction, and the 3-bit immediate-format code consumed by the decode-stage immediate generator.

## Interface
- RESET_PC, 64'h0000_0000_0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous reset, active-high
- imem_req_valid  out  1  request address valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  64  fetch address (bits [1:0] always 0)
- imem_resp_valid  in  1  instruction returned this cycle
- imem_resp_data  in  32  returned instruction
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  64  new PC; bits [1:0] ignored (forced 0)
- stall  in  1  decode cannot accept; hold IF/ID
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_pc  out  64  PC of ifid_instr
- ifid_instr  out  32  instruction
- ifid_imm_type  out  3  0 I, 1 U, 2 S, 3 R/none, 4 SB, 5 UJ
- ifid_illegal  out  1  opcode not in the supported set

## Operation
- State: pc_q (next address to request), req_pc_q (address of the outstanding request), FSM {REQ, WAIT, DROP}, skid {valid, pc, instr}.
- imem_req_valid = !reset && !redirect_valid && !skid.valid && (state==REQ || (state==WAIT && imem_resp_valid && !stall_to_skid)). stall_to_skid = stall && ifid_valid. imem_req_addr = pc_q.
- Request accepted (valid&&ready): req_pc_q<=pc_q, pc_q<=pc_q+4 (wraps modulo 2^64), state<=WAIT.
- REQ: stays until accepted.
- WAIT: on imem_resp_valid the instruction is delivered with pc=req_pc_q. If a new request is accepted the same cycle, the FSM stays in WAIT; otherwise it goes to REQ.
- DROP: on imem_resp_valid the data is discarded and the FSM goes to REQ. No request is issued in DROP.
- Delivery when !stall: skid.valid → IF/ID<=skid, skid cleared (a response that cycle cannot occur, since requests are blocked while skid is valid). Else resp delivered → IF/ID<=resp. Else ifid_valid<=0.
- Delivery when stall: IF/ID holds. A delivered response goes to skid if ifid_valid; otherwise it loads IF/ID directly.
- Redirect (highest priority, beats stall): pc_q<={redirect_pc[63:2],2'b00}, ifid_valid<=0, skid.valid<=0, no request this cycle. The FSM goes WAIT→DROP, unless imem_resp_valid occurs the same cycle, in which case that response is discarded and the FSM goes to REQ. REQ stays REQ. DROP stays DROP.
- imm_type decode on opcode [6:0]: 0010011/0000011/1100111/0011011→0; 0110111/0010111→1; 0100011→2; 0110011/0111011→3; 1100011→4; 1101111→5. Any other opcode→3 with ifid_illegal=1. The decode is registered alongside ifid_instr.

## Timing
- Reset values: ifid_valid 0, ifid_pc 0, ifid_instr 32'h0000_0013 (NOP), ifid_imm_type 0, ifid_illegal 0, skid empty, FSM REQ, pc_q RESET_PC. imem_req_valid is 0 during reset and 1 in the first cycle after reset.
- Reset mid-WAIT: any later response is ignored only if it arrives while the FSM is in REQ. The memory must also be reset.
- Latency: request accepted in cycle N, response in N+k (k≥1), ifid_valid in N+k+1.
- Throughput: 1 instruction/cycle when k=1 and there is no stall.
- Skid never overflows because there is at most one outstanding request and no request is issued while skid is valid.

## Structure
- Package fetch_pkg: imm_type_e enum (I=0,U=1,S=2,R=3,SB=4,UJ=5, 3 bits, shared with the immediate generator), opcode localparams, NOP_INSTR constant.
- Sub-module imm_type_decode: combinational opcode → {imm_type, illegal}.
- Everything else lives in fetch_stage.

## Test plan
- Reset with RESET_PC=0x1000 and a k=1 memory → addresses 0x1000, 0x1004, 0x1008 on consecutive cycles; ifid_pc follows one cycle after each response; no bubbles.
- Stall for 3 cycles while a response arrives → the response lands in skid and no new request is issued; on stall release ifid shows the skid entry, then fetch resumes at the next PC with no loss or duplication.
- Redirect to 0x2002 while in WAIT, response arriving 2 cycles later → the response is dropped, the next request is 0x2000, and ifid_valid stays 0 until the 0x2000 instruction arrives.
- Redirect, stall, and response in the same cycle → the response is discarded, ifid_valid=0, skid empty, the next request is the redirect PC.
- Instructions 0x00A00093 (addi), 0x00112023 (sd), 0xFE000EE3 (beq), 0x0000006F (jal), 0x12345037 (lui), 0xFFFFFFFF → imm_type 0, 2, 4, 5, 1, 3; ifid_illegal set only for the last.
- pc_q=0xFFFF_FFFF_FFFF_FFFC accepted → next request address is 0x0.
